// File: rtl/llc_input_scheduler.sv
// -----------------------------------------------------------------------------
// llc_input_scheduler
//
// Picks one of three incoming LLC message channels (response, CPU request,
// DMA request) and walks the chosen transaction through a fixed
// DECODE -> RD_SET -> PROCESS sequence before it accepts the next one.
//
// Handshake: the *_valid inputs are level-held requests with no ready.
// A channel is considered consumed when its bit shows up in grant (visible
// together with the decode_en strobe). The producer must keep its message
// stable until then. proc_done is a single-cycle completion pulse from the
// datapath, and it only counts while in PROCESS.
//
// Optional feature: define LLC_STARVE_GUARD_EN to enable the DMA starvation
// guard. Without the guard the arbitration is strict rsp > req > dma and
// starve_cnt is tied to 0.
//
// Parameters
//   STARVE_LIMIT   number of rsp/req grants tolerated while DMA waits (1..15)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   rsp_valid      response channel has a message
//   req_valid      CPU request channel has a message
//   dma_req_valid  DMA request channel has a message
//   req_stall      set conflict, so req and dma are not eligible
//   recall_pending recall outstanding, so only rsp is eligible
//   proc_done      datapath finished the current transaction
//   decode_en      one-cycle strobe into the input decoder
//   rd_set_en      one-cycle strobe to read the set
//   grant          one-hot {dma,req,rsp} of the current transaction, 0 when idle
//   busy           high whenever the FSM is not in IDLE
//   starve_cnt     current DMA starvation count
// -----------------------------------------------------------------------------
module llc_input_scheduler #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rsp_valid,
   input  logic       req_valid,
   input  logic       dma_req_valid,
   input  logic       req_stall,
   input  logic       recall_pending,
   input  logic       proc_done,
   output logic       decode_en,
   output logic       rd_set_en,
   output logic [2:0] grant,
   output logic       busy,
   output logic [3:0] starve_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DECODE  = 2'd1,
      RD_SET  = 2'd2,
      PROCESS = 2'd3
   } state_t;

   localparam logic [2:0] G_RSP = 3'b001;
   localparam logic [2:0] G_REQ = 3'b010;
   localparam logic [2:0] G_DMA = 3'b100;

   state_t     state_q;
   logic [2:0] grant_q;
   logic       decode_en_q;
   logic       rd_set_en_q;
   logic       busy_q;

   logic       rsp_el;
   logic       req_el;
   logic       dma_el;
   logic       guard_hit;
   logic [2:0] grant_sel;

   // A set conflict or an outstanding recall only blocks new requests;
   // responses must always drain.
   assign rsp_el = rsp_valid;
   assign req_el = req_valid & ~req_stall & ~recall_pending;
   assign dma_el = dma_req_valid & ~req_stall & ~recall_pending;

`ifdef LLC_STARVE_GUARD_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_q;

   // DMA has been passed over LIMIT times while eligible: it jumps the queue.
   assign guard_hit = (starve_q == LIMIT) & dma_el;

   // The counter only moves in IDLE, where grant decisions are made. A DMA
   // grant, or DMA having nothing to send, ends the starvation episode.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
      end else if (state_q == IDLE) begin
         if (!dma_req_valid || grant_sel == G_DMA) begin
            starve_q <= '0;
         end else if ((grant_sel != 3'b000) && dma_el && (starve_q != LIMIT)) begin
            starve_q <= starve_q + 4'd1;
         end
      end
   end

   assign starve_cnt = starve_q;
`else
   assign guard_hit  = 1'b0;
   assign starve_cnt = 4'd0;
`endif

   // Fixed priority rsp > req > dma, overridden by the starvation guard.
   always_comb begin
      grant_sel = 3'b000;
      if (guard_hit) begin
         grant_sel = G_DMA;
      end else if (rsp_el) begin
         grant_sel = G_RSP;
      end else if (req_el) begin
         grant_sel = G_REQ;
      end else if (dma_el) begin
         grant_sel = G_DMA;
      end
   end

   // All outputs are registered alongside the state, so each strobe lines up
   // exactly with the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= 3'b000;
         decode_en_q <= 1'b0;
         rd_set_en_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         decode_en_q <= 1'b0;
         rd_set_en_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_sel != 3'b000) begin
                  state_q     <= DECODE;
                  grant_q     <= grant_sel;
                  decode_en_q <= 1'b1;
                  busy_q      <= 1'b1;
               end else begin
                  grant_q <= 3'b000;
               end
            end
            DECODE: begin
               state_q     <= RD_SET;
               rd_set_en_q <= 1'b1;
            end
            RD_SET: begin
               state_q <= PROCESS;
            end
            PROCESS: begin
               if (proc_done) begin
                  state_q <= IDLE;
                  grant_q <= 3'b000;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= 3'b000;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign decode_en = decode_en_q;
   assign rd_set_en = rd_set_en_q;
   assign grant     = grant_q;
   assign busy      = busy_q;

endmodule

// File: doc/llc_input_scheduler.md
LLC_INPUT_SCHEDULER -- requirements
Module: llc_input_scheduler

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, number of non-DMA grants tolerated while DMA waits (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: rsp_valid  input  1  response channel has a message.
REQ-005 SHALL have port: req_valid  input  1  CPU request channel has a message.
REQ-006 SHALL have port: dma_req_valid  input  1  DMA request channel has a message.
REQ-007 SHALL have port: req_stall  input  1  set conflict; blocks req and DMA eligibility.
REQ-008 SHALL have port: recall_pending  input  1  recall outstanding; only rsp eligible.
REQ-009 SHALL have port: proc_done  input  1  datapath finished the current transaction.
REQ-010 SHALL have port: decode_en  output  1  one-cycle strobe into the input decoder.
REQ-011 SHALL have port: rd_set_en  output  1  one-cycle strobe to read the set.
REQ-012 SHALL have port: grant  output  3  one-hot {dma,req,rsp} of current transaction; 0 when idle.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port: starve_cnt  output  4  current DMA starvation count.

Function
REQ-015 SHALL implement FSM states IDLE, DECODE, RD_SET, PROCESS.
REQ-016 SHALL define eligibility: rsp = rsp_valid; req = req_valid & !req_stall & !recall_pending; dma = dma_req_valid & !req_stall & !recall_pending.
REQ-017 SHALL, in IDLE with any eligible channel, register grant and move to DECODE next cycle; else remain in IDLE with grant=0.
REQ-018 SHALL select grant by fixed priority rsp > req > dma, except as in REQ-024.
REQ-019 SHALL assert decode_en only in DECODE (exactly one cycle), then move to RD_SET.
REQ-020 SHALL assert rd_set_en only in RD_SET (exactly one cycle), then move to PROCESS.
REQ-021 SHALL hold grant constant from DECODE through PROCESS regardless of input changes.
REQ-022 SHALL leave PROCESS for IDLE on the cycle after proc_done=1; proc_done in any other state is ignored.
REQ-023 SHALL give latency: eligible in IDLE at cycle N -> decode_en at N+1, rd_set_en at N+2, PROCESS from N+3; proc_done at M -> earliest next decode_en at M+2.

Configuration
REQ-024 SHALL, with macro LLC_STARVE_GUARD_EN defined: increment starve_cnt (saturating at STARVE_LIMIT) on each rsp/req grant made while dma eligible; when starve_cnt==STARVE_LIMIT and dma eligible, grant dma above req and rsp; clear starve_cnt on dma grant or on any IDLE cycle with dma_req_valid=0.
REQ-025 SHALL, without LLC_STARVE_GUARD_EN: strict priority only, starve_cnt tied to 0, no counter logic.

Reset
REQ-026 SHALL, with rst=1 at a rising edge, enter IDLE, clear grant and starve_cnt, drive decode_en=rd_set_en=busy=0 the following cycle.
REQ-027 SHALL, on reset mid-transaction (any state), abandon it without a further decode_en/rd_set_en; reset overrides proc_done.
REQ-028 SHALL ignore all inputs while rst=1.

Verification
REQ-029 SHALL cover: rsp_valid=req_valid=dma_req_valid=1 in IDLE -> grant=001, decode_en at N+1, rd_set_en at N+2, busy through proc_done+1.
REQ-030 SHALL cover: req_valid=1, req_stall=1, rsp_valid=0 -> stays IDLE, grant=000, no strobes; drop req_stall -> grant=010.
REQ-031 SHALL cover: recall_pending=1, req_valid=dma_req_valid=1, rsp_valid=0 -> no grant; then rsp_valid=1 -> grant=001.
REQ-032 SHALL cover: proc_done pulsed in DECODE and RD_SET -> ignored, FSM still reaches PROCESS and waits for a later proc_done.
REQ-033 SHALL cover (guard enabled, STARVE_LIMIT=4): req_valid and dma_req_valid held 1 -> four req grants, starve_cnt 1..4, fifth grant=100, starve_cnt returns to 0; guard disabled -> grant stays 010 indefinitely.
REQ-034 SHALL cover: rst asserted in PROCESS -> next cycle IDLE, busy=0, grant=000, starve_cnt=0, no strobe.
